// File: rtl/minmax_seq.sv
// -----------------------------------------------------------------------------
// minmax_seq
//   Per-frame running maximum / minimum of N 4-bit samples. A frame starts on
//   an accepted start pulse. The first sample seeds both extremes. Each later
//   sample is latched and then checked against max_out and against min_out in
//   two separate cycles. A single 4-bit magnitude comparator serves both
//   checks. The comparison is signed or unsigned according to the mode that
//   was latched at frame start.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset (release is synchronised)
//   start     in   frame start request, honoured only in IDLE
//   mode      in   1 = signed 4-bit, 0 = unsigned 4-bit; latched on start
//   in_data   in   [3:0] sample value
//   in_valid  in   sample offered this cycle
//   in_ready  out  block accepts a sample this cycle
//   max_out   out  [3:0] running maximum of the frame
//   min_out   out  [3:0] running minimum of the frame
//   cnt       out  [3:0] samples accepted in the current frame
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module minmax_seq #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] max_out,
  output logic [3:0] min_out,
  output logic [3:0] cnt,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] N_L = 4'(N);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    ACCEPT,
    CMP_MAX,
    CMP_MIN,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] sample;
  logic       mode_lat;

  // Reset release is delayed by two flops. State can therefore first change
  // on the third rising edge after rst_n goes high. Reset assertion still
  // acts immediately, because every flop below is cleared directly by rst_n.
  logic [1:0] sync;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign run = sync[1];

  // Single shared comparator. The second operand is chosen by state. In
  // signed mode, flipping the MSB of both operands turns two's-complement
  // ordering into plain unsigned ordering.
  logic [3:0] cmp_b;
  logic [3:0] key_a;
  logic [3:0] key_b;
  logic       cmp_gt;
  logic       cmp_eq;
  logic       cmp_lt;

  always_comb begin
    cmp_b  = (state == CMP_MIN) ? min_out : max_out;
    key_a  = {sample[3] ^ mode_lat, sample[2:0]};
    key_b  = {cmp_b[3] ^ mode_lat, cmp_b[2:0]};
    cmp_gt = (key_a > key_b);
    cmp_eq = (key_a == key_b);
    cmp_lt = !cmp_gt && !cmp_eq;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (run) begin
      state <= state_next;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CMP_MAX;
      end
      CMP_MAX: begin
        state_next = CMP_MIN;
      end
      CMP_MIN: begin
        state_next = (cnt == N_L) ? DONE : ACCEPT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_out  <= 4'd0;
      min_out  <= 4'd0;
      cnt      <= 4'd0;
      sample   <= 4'd0;
      mode_lat <= 1'b0;
    end else if (run) begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_lat <= mode;
            cnt      <= 4'd0;
          end
        end
        FIRST: begin
          if (in_valid) begin
            max_out <= in_data;
            min_out <= in_data;
            cnt     <= 4'd1;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            sample <= in_data;
            cnt    <= cnt + 4'd1;
          end
        end
        CMP_MAX: begin
          // A tie leaves max_out unchanged.
          if (cmp_gt) max_out <= sample;
        end
        CMP_MIN: begin
          // A tie leaves min_out unchanged.
          if (cmp_lt) min_out <= sample;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_seq.sv
// -----------------------------------------------------------------------------
// tb_minmax_seq
//   Three instances of minmax_seq with N = 4, 3 and 8, each with its own
//   stimulus signals. The bench applies a table of directed frames, then
//   random frames checked against a reference model, then a mid-frame reset
//   followed by a fresh frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_minmax_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_v [3];
  logic       mode_v  [3];
  logic       valid_v [3];
  logic [3:0] data_v  [3];
  logic       ready_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [3:0] max_v   [3];
  logic [3:0] min_v   [3];
  logic [3:0] cnt_v   [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NP = (gi == 0) ? 4 : (gi == 1) ? 3 : 8;
      minmax_seq #(.N(NP)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_v[gi]),
        .mode     (mode_v[gi]),
        .in_data  (data_v[gi]),
        .in_valid (valid_v[gi]),
        .in_ready (ready_v[gi]),
        .max_out  (max_v[gi]),
        .min_out  (min_v[gi]),
        .cnt      (cnt_v[gi]),
        .busy     (busy_v[gi]),
        .done     (done_v[gi])
      );
    end
  endgenerate

  int tests = 0;
  int fails = 0;

  logic [3:0] cur_smp [16];

  function automatic int nval(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 3 : 8;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  // Reference model: interpret each sample as an integer and take the
  // largest or smallest of the first n samples. On a tie, keep the earliest.
  function automatic int sval(input logic [3:0] v, input logic m);
    if (m && v[3]) return int'(v) - 16;
    return int'(v);
  endfunction

  function automatic logic [3:0] ref_ext(input int n, input logic m, input bit want_max);
    logic [3:0] b;
    b = cur_smp[0];
    for (int i = 1; i < n; i++) begin
      if (want_max ? (sval(cur_smp[i], m) > sval(b, m))
                   : (sval(cur_smp[i], m) < sval(b, m)))
        b = cur_smp[i];
    end
    return b;
  endfunction

  // Runs one frame on instance idx using samples from cur_smp.
  task automatic run_frame(input int idx, input logic m, input bit gaps, input bit poke,
                           input logic [3:0] exp_max, input logic [3:0] exp_min,
                           input string tag);
    int n;
    int hs;
    int j;
    int done_j;
    int low_left;
    n        = nval(idx);
    hs       = 0;
    done_j   = -1;
    low_left = 0;
    @(negedge clk);
    start_v[idx] = 1'b1;
    mode_v[idx]  = m;
    valid_v[idx] = 1'b0;
    @(negedge clk);
    start_v[idx] = 1'b0;
    mode_v[idx]  = ~m;                 // must not affect the frame in flight
    chk("start_busy", busy_v[idx], 1);
    j = 1;
    while (j < 300) begin
      chk("cnt_track", cnt_v[idx], hs);
      if (ready_v[idx] && hs >= 1 && !done_v[idx]) begin
        chk("run_max", max_v[idx], ref_ext(hs, m, 1'b1));
        chk("run_min", min_v[idx], ref_ext(hs, m, 1'b0));
      end
      start_v[idx] = 1'b0;
      if (low_left > 0) begin
        chk("ready_low_cmp", ready_v[idx], 0);
        if (low_left == 2 && poke) start_v[idx] = 1'b1;   // CMP_MAX cycle
        low_left--;
      end
      if (done_v[idx]) begin
        done_j = j;
        break;
      end
      valid_v[idx] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_v[idx]  = (hs < n) ? cur_smp[hs] : 4'($urandom_range(0, 15));
      if (ready_v[idx] && valid_v[idx]) begin
        hs++;
        if (hs >= 2) low_left = 2;
      end
      @(negedge clk);
      j++;
    end
    if (done_j < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("final_max", max_v[idx], exp_max);
      chk("final_min", min_v[idx], exp_min);
      chk("final_cnt", cnt_v[idx], n);
      chk("handshakes", hs, n);
      if (!gaps) chk("done_spacing", done_j - 1, 1 + 3 * (n - 1));
      // DONE cycle: extra sample offered, optional start poke
      valid_v[idx] = 1'b1;
      data_v[idx]  = 4'($urandom_range(0, 15));
      start_v[idx] = poke;
      @(negedge clk);
      start_v[idx] = 1'b0;
      valid_v[idx] = 1'b0;
      chk("done_pulse", done_v[idx], 0);
      chk("idle_busy", busy_v[idx], 0);
      chk("idle_ready", ready_v[idx], 0);
      chk("hold_max", max_v[idx], exp_max);
      chk("hold_min", min_v[idx], exp_min);
      chk("hold_cnt", cnt_v[idx], n);
      @(negedge clk);
      chk("no_restart", busy_v[idx], 0);
    end
    $display("[TB] frame %s N=%0d mode=%0d max=%h min=%h cnt=%0d", tag, n, m,
             max_v[idx], min_v[idx], cnt_v[idx]);
  endtask

  typedef struct packed {
    logic [1:0]  idx;
    logic        m;
    logic [31:0] s;      // sample k in bits [4k+3:4k]
    logic [3:0]  emax;
    logic [3:0]  emin;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      valid_v[i] = 1'b0;
      data_v[i]  = 4'd0;
    end
    tbl[0] = '{2'd0, 1'b0, 32'h0000_9093, 4'h9, 4'h0};   // 3,9,0,9 unsigned
    tbl[1] = '{2'd0, 1'b1, 32'h0000_0F87, 4'h7, 4'h8};   // 7,8,F,0 signed
    tbl[2] = '{2'd0, 1'b0, 32'h0000_0F87, 4'hF, 4'h0};   // 7,8,F,0 unsigned
    tbl[3] = '{2'd1, 1'b0, 32'h0000_0555, 4'h5, 4'h5};   // all equal
    tbl[4] = '{2'd1, 1'b1, 32'h0000_0555, 4'h5, 4'h5};
    tbl[5] = '{2'd0, 1'b1, 32'h0000_7878, 4'h7, 4'h8};   // -8 < +7 signed
    tbl[6] = '{2'd0, 1'b0, 32'h0000_7878, 4'h8, 4'h7};   // 8 > 7 unsigned
    tbl[7] = '{2'd2, 1'b1, 32'h3078_21EF, 4'h7, 4'h8};   // N=8 signed

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_max", max_v[i], 0);
      chk("rst_min", min_v[i], 0);
      chk("rst_cnt", cnt_v[i], 0);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_ready", ready_v[i], 0);
      chk("rst_done", done_v[i], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 8; k++) cur_smp[k] = tbl[t].s[4*k +: 4];
      run_frame(int'(tbl[t].idx), tbl[t].m, 1'b0, (t >= 5), tbl[t].emax, tbl[t].emin,
                $sformatf("table%0d", t));
    end

    // Random frames against the reference model
    for (int r = 0; r < 12; r++) begin
      int idx;
      logic m;
      idx = $urandom_range(0, 2);
      m   = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) cur_smp[k] = 4'($urandom_range(0, 15));
      run_frame(idx, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ref_ext(nval(idx), m, 1'b1), ref_ext(nval(idx), m, 1'b0),
                $sformatf("rand%0d", r));
    end

    // Mid-frame reset on the N=8 instance
    @(negedge clk);
    start_v[2] = 1'b1;
    mode_v[2]  = 1'b0;
    @(negedge clk);
    start_v[2] = 1'b0;
    valid_v[2] = 1'b1;
    for (int k = 0; k < 40 && cnt_v[2] != 4'd2; k++) begin
      data_v[2] = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("abort_cnt2", cnt_v[2], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_max", max_v[2], 0);
    chk("abort_min", min_v[2], 0);
    chk("abort_cnt", cnt_v[2], 0);
    chk("abort_busy", busy_v[2], 0);
    chk("abort_ready", ready_v[2], 0);
    valid_v[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done_v[2], 0);
    end
    rst_n = 1'b1;
    start_v[2] = 1'b1;
    @(negedge clk);
    chk("release_hold", busy_v[2], 0);
    start_v[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("release_idle", busy_v[2], 0);
    for (int k = 0; k < 8; k++) cur_smp[k] = 4'($urandom_range(0, 15));
    run_frame(2, 1'b1, 1'b0, 1'b0, ref_ext(8, 1'b1, 1'b1), ref_ext(8, 1'b1, 1'b0),
              "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
